song_player: RTL
================

# song_player

Plays the melody selected by the 3-bit song index from the song selector. It steps through a per-song note ROM at a fixed beat rate and drives a square-wave buzzer output. It is the consumer of the selector's index and sits between the button/selector logic and the board's piezo pin.

## Interface
- CLK_HZ, 100_000_000 — system clock frequency in Hz; used to derive half-period counts.
- BEAT_CYCLES, 25_000_000 — clock cycles per beat.
- GAP_CYCLES, 2_500_000 — silent articulation cycles at the end of every note. Must be less than BEAT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- song  in  3  selected song index. Values 0..2 are valid; 3..7 select no song.
- play  in  1  level enable. High means play; low means stop and rewind.
- buzzer  out  1  square-wave tone output; 0 when silent.
- playing  out  1  high while in NOTE or GAP.
- note_idx  out  5  ROM entry currently sounding (0..31).
- pitch  out  4  pitch code of the current entry.

## Operation
- ROM entry format: {pitch[3:0], dur[1:0]}, with 32 entries per song.
  - dur 1..3 is the note length in beats; dur 0 is treated as 1.
- Pitch codes:
  - 0 = rest (buzzer held 0).
  - 1..7 = C4 D4 E4 F4 G4 A4 B4 (262 294 330 349 392 440 494 Hz).
  - 8..14 = C5..B5 (523 587 659 698 784 880 988 Hz).
  - 15 = END marker.
- Half period is CLK_HZ/(2*f), using truncating integer division, computed at elaboration. Counter width must cover C4.
- ROM contents (pitch:dur):
  - Song 0: 1:1 1:1 5:1 5:1 6:1 6:1 5:2 END.
  - Song 1: 3:1 2:1 1:1 2:1 3:1 3:1 3:2 END.
  - Song 2: 1:1 2:1 3:1 1:1 1:1 2:1 3:1 1:1 END.
- States: IDLE, LOAD, NOTE, GAP, DONE.
- IDLE:
  - Outputs are silent and note_idx=0.
  - Go to LOAD when play=1 and song<=2.
- LOAD: registered ROM read of entry note_idx.
  - Pitch 15 goes to DONE.
  - Any other pitch goes to NOTE, and the duration counter is loaded with dur*BEAT_CYCLES.
- NOTE: buzzer toggles every half-period cycles while the pitch is non-zero. After dur*BEAT_CYCLES−GAP_CYCLES cycles, go to GAP.
- GAP: buzzer=0. After GAP_CYCLES cycles, increment note_idx and go to LOAD.
- note_idx wraps from 31 to 0.
- DONE:
  - buzzer=0, playing=0.
  - Stays here until play falls or song changes.
- play low in any state: go to IDLE on the next edge, with buzzer=0 and note_idx=0.
- song change: song is registered every cycle. A change while not in IDLE goes to IDLE, rewinds, and is then re-evaluated. This means a new song restarts at entry 0 without needing a play toggle.
- Priority when events coincide: rst > play low > song change > normal transition.

## Timing
- Reset values: buzzer=0, playing=0, note_idx=0, pitch=0, state IDLE, all counters 0.
- Start latency:
  - play sampled high in IDLE at edge k.
  - LOAD at k+1.
  - NOTE at k+2, with playing=1 and pitch valid from k+2.
- The first buzzer rise occurs half-period cycles after entering NOTE, starting from buzzer=0.
- Each note occupies exactly dur*BEAT_CYCLES cycles across NOTE+GAP, plus 1 LOAD cycle between notes.
- The tone counter resets at every NOTE entry, so no phase carries over between notes.
- Reset asserted mid-note: outputs go to their reset values immediately (asynchronous), with no pending toggle afterwards.

## Configuration
- LOOP_EN defined: reaching END wraps to entry 0 (LOAD of entry 0) instead of DONE, so the song repeats indefinitely while play=1.
- LOOP_EN undefined: END goes to DONE, and the song plays once.

## Test plan
Bench settings: CLK_HZ=100_000, BEAT_CYCLES=1000, GAP_CYCLES=100. This gives C4 half=190 and A4 half=113.
- Reset: rst=1 mid-note in song 0 → buzzer, playing, note_idx and pitch are all 0 within the same cycle, and remain 0 after release with play=0.
- Start song 0:
  - play↑ → playing=1 two cycles later, with pitch=1.
  - buzzer period is 380 cycles.
  - buzzer=0 for the last 100 of the first 1000 cycles.
  - note_idx=1 at cycle 1001 after NOTE entry.
- Note length:
  - In song 0, entry 6 (G4, 2 beats) lasts 2000 cycles.
  - END follows, then playing=0 (LOOP_EN off) or note_idx=0 with pitch=1 (LOOP_EN on).
- Song change mid-note: song 0→1 during entry 3 → IDLE, then LOAD, then NOTE with note_idx=0 and pitch=3, within 3 cycles.
- Invalid song: song=5 with play=1 → playing stays 0 and buzzer stays 0 for 5000 cycles.
- Stop: play↓ during GAP → IDLE on the next edge with note_idx=0. play↑ again → restarts at entry 0.

Source files
------------

// File: rtl/song_player.sv
// song_player: steps through a per-song note ROM at a fixed beat rate and
// drives a square-wave buzzer. Each note is split into a sounding part (NOTE)
// and a silent articulation tail (GAP), with one LOAD cycle between notes.
// Optional build macro: LOOP_EN -- when defined, reaching the END marker
// restarts the song at entry 0 instead of stopping in DONE.
module song_player #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] song,
    input  logic       play,
    output logic       buzzer,
    output logic       playing,
    output logic [4:0] note_idx,
    output logic [3:0] pitch
);

    // C4 has the longest half period, so it sets the tone counter width.
    localparam int HALF_MAX = CLK_HZ / (2 * 262);
    localparam int HALF_W   = $clog2(HALF_MAX + 1);
    // Longest note is three beats.
    localparam int DUR_W    = $clog2(3 * BEAT_CYCLES + 1);

    localparam logic [3:0] PITCH_REST = 4'd0;
    localparam logic [3:0] PITCH_END  = 4'd15;
    localparam logic [5:0] ROM_END    = {PITCH_END, 2'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP,
        S_DONE
    } state_t;

    // Tone frequency in Hz for each pitch code; 0 for rest and END.
    function automatic int freq_hz(input int p);
        case (p)
            1:       return 262;
            2:       return 294;
            3:       return 330;
            4:       return 349;
            5:       return 392;
            6:       return 440;
            7:       return 494;
            8:       return 523;
            9:       return 587;
            10:      return 659;
            11:      return 698;
            12:      return 784;
            13:      return 880;
            14:      return 988;
            default: return 0;
        endcase
    endfunction

    // Melody ROM: {pitch, dur}; everything past the listed notes reads as END.
    function automatic logic [5:0] rom_entry(input logic [2:0] s, input logic [4:0] i);
        logic [5:0] r;
        r = ROM_END;
        case (s)
            3'd0: begin
                case (i)
                    5'd0:    r = {4'd1, 2'd1};
                    5'd1:    r = {4'd1, 2'd1};
                    5'd2:    r = {4'd5, 2'd1};
                    5'd3:    r = {4'd5, 2'd1};
                    5'd4:    r = {4'd6, 2'd1};
                    5'd5:    r = {4'd6, 2'd1};
                    5'd6:    r = {4'd5, 2'd2};
                    default: r = ROM_END;
                endcase
            end
            3'd1: begin
                case (i)
                    5'd0:    r = {4'd3, 2'd1};
                    5'd1:    r = {4'd2, 2'd1};
                    5'd2:    r = {4'd1, 2'd1};
                    5'd3:    r = {4'd2, 2'd1};
                    5'd4:    r = {4'd3, 2'd1};
                    5'd5:    r = {4'd3, 2'd1};
                    5'd6:    r = {4'd3, 2'd2};
                    default: r = ROM_END;
                endcase
            end
            3'd2: begin
                case (i)
                    5'd0:    r = {4'd1, 2'd1};
                    5'd1:    r = {4'd2, 2'd1};
                    5'd2:    r = {4'd3, 2'd1};
                    5'd3:    r = {4'd1, 2'd1};
                    5'd4:    r = {4'd1, 2'd1};
                    5'd5:    r = {4'd2, 2'd1};
                    5'd6:    r = {4'd3, 2'd1};
                    5'd7:    r = {4'd1, 2'd1};
                    default: r = ROM_END;
                endcase
            end
            default: r = ROM_END;
        endcase
        return r;
    endfunction

    // Half-period table, fully constant after elaboration.
    logic [HALF_W-1:0] half_tab [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_half
            localparam int F = freq_hz(gi);
            if (F == 0) begin : g_silent
                assign half_tab[gi] = '0;
            end else begin : g_tone
                assign half_tab[gi] = HALF_W'(CLK_HZ / (2 * F));
            end
        end
    endgenerate

    state_t            state_q, state_d;
    logic [2:0]        song_q, song_d;
    logic [4:0]        note_idx_q, note_idx_d;
    logic [3:0]        pitch_q, pitch_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic [HALF_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              buzzer_q, buzzer_d;

    logic [5:0]        rom_word;
    logic [3:0]        rom_pitch;
    logic [1:0]        rom_dur;
    logic [HALF_W-1:0] half_cur;
    logic              song_changed;

    // State, counters and outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            song_q     <= 3'd0;
            note_idx_q <= 5'd0;
            pitch_q    <= 4'd0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            note_idx_q <= note_idx_d;
            pitch_q    <= pitch_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    // Next-state logic: stop and song change override the normal sequence.
    always_comb begin
        state_d    = state_q;
        song_d     = song;
        note_idx_d = note_idx_q;
        pitch_d    = pitch_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        buzzer_d   = buzzer_q;

        rom_word     = rom_entry(song_q, note_idx_q);
        rom_pitch    = rom_word[5:2];
        rom_dur      = rom_word[1:0];
        half_cur     = half_tab[pitch_q];
        song_changed = (song != song_q);

        if (!play || (song_changed && state_q != S_IDLE)) begin
            // Rewind; IDLE re-evaluates play/song on the following edge.
            state_d    = S_IDLE;
            note_idx_d = 5'd0;
            pitch_d    = 4'd0;
            dur_cnt_d  = '0;
            tone_cnt_d = '0;
            buzzer_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    note_idx_d = 5'd0;
                    pitch_d    = 4'd0;
                    buzzer_d   = 1'b0;
                    tone_cnt_d = '0;
                    if (song <= 3'd2) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    buzzer_d   = 1'b0;
                    tone_cnt_d = '0;
                    if (rom_pitch == PITCH_END) begin
`ifdef LOOP_EN
                        // Read entry 0 on the next cycle and keep going.
                        note_idx_d = 5'd0;
                        state_d    = S_LOAD;
`else
                        pitch_d = 4'd0;
                        state_d = S_DONE;
`endif
                    end else begin
                        pitch_d = rom_pitch;
                        case (rom_dur)
                            2'd2:    dur_cnt_d = DUR_W'(2 * BEAT_CYCLES);
                            2'd3:    dur_cnt_d = DUR_W'(3 * BEAT_CYCLES);
                            default: dur_cnt_d = DUR_W'(BEAT_CYCLES);
                        endcase
                        state_d = S_NOTE;
                    end
                end
                S_NOTE: begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (pitch_q != PITCH_REST) begin
                        if (tone_cnt_q == half_cur - HALF_W'(1)) begin
                            tone_cnt_d = '0;
                            buzzer_d   = ~buzzer_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + HALF_W'(1);
                        end
                    end else begin
                        buzzer_d = 1'b0;
                    end
                    // Counter still holds the GAP length plus this cycle.
                    if (dur_cnt_q == DUR_W'(GAP_CYCLES + 1)) begin
                        state_d    = S_GAP;
                        buzzer_d   = 1'b0;
                        tone_cnt_d = '0;
                    end
                end
                S_GAP: begin
                    buzzer_d  = 1'b0;
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (dur_cnt_q == DUR_W'(1)) begin
                        note_idx_d = note_idx_q + 5'd1;
                        state_d    = S_LOAD;
                    end
                end
                S_DONE: begin
                    buzzer_d = 1'b0;
                    pitch_d  = 4'd0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign buzzer   = buzzer_q;
    assign playing  = (state_q == S_NOTE) || (state_q == S_GAP);
    assign note_idx = note_idx_q;
    assign pitch    = pitch_q;

endmodule
